axil_addr_fifo: RTL and testbench

Parametrised AXI4-Lite address-channel buffer between an upstream master port and a downstream slave port, usable on either the write-address (AW) or read-address (AR) channel. Holds up to DEPTH outstanding address/protection beats, enforces AXI VALID/READY stability rules on its master-facing output, and optionally forces alignment to the data-bus width while flagging misaligned requests. It supersedes the single-register write-address stage in the AXI4-Lite interconnect path.

---
 rtl/axil_addr_fifo.sv | 104 ++++++++++
 tb/tb_axil_addr_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/axil_addr_fifo.sv
// AXI4-Lite address-channel FIFO (AW or AR): buffers DEPTH {ADDR, PROT} beats,
// optionally aligns addresses to the data-bus width and flags misaligned requests.
module axil_addr_fifo #(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ALIGN_MODE = 0
) (
   input  logic                         ACLK,
   input  logic                         ARESETn,
   input  logic                         s_AVALID,
   output logic                         s_AREADY,
   input  logic [ADDR_WIDTH-1:0]        s_AADDR,
   input  logic [2:0]                   s_APROT,
   output logic                         m_AVALID,
   input  logic                         m_AREADY,
   output logic [ADDR_WIDTH-1:0]        m_AADDR,
   output logic [2:0]                   m_APROT,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_misaligned
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int OFS_W = $clog2(DATA_WIDTH / 8);

   logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
   logic [2:0]            prot_mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  ready_en;
   logic                  misaligned;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] wr_addr;

   // Flags come only from registered state, so no input reaches an output combinationally.
   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign s_AREADY = ready_en && !full;
   assign m_AVALID = !empty;
   assign push     = s_AVALID && s_AREADY;
   assign pop      = m_AVALID && m_AREADY;

   assign m_AADDR      = addr_mem[rd_ptr];
   assign m_APROT      = prot_mem[rd_ptr];
   assign o_count      = count;
   assign o_misaligned = misaligned;

   always_comb begin
      wr_addr = s_AADDR;
      if (ALIGN_MODE != 0) begin
         wr_addr[OFS_W-1:0] = '0;
      end
   end

   // Holds s_AREADY low until the first clock edge after reset release.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   // Storage is cleared on reset so the head outputs read zero.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem[i] <= '0;
            prot_mem[i] <= '0;
         end
      end else if (push) begin
         addr_mem[wr_ptr] <= wr_addr;
         prot_mem[wr_ptr] <= s_APROT;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         misaligned <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         misaligned <= push && (s_AADDR[OFS_W-1:0] != '0);
      end
   end

endmodule

// File: tb/tb_axil_addr_fifo.sv
// Bench for axil_addr_fifo: driver pushes expected beats into a queue, a negedge
// monitor checks the head against it and retires entries on each pop.
module tb_axil_addr_fifo;

   logic        ACLK;
   logic        ARESETn;
   logic        s_AVALID;
   logic        s_AREADY;
   logic [31:0] s_AADDR;
   logic [2:0]  s_APROT;
   logic        m_AVALID;
   logic        m_AREADY;
   logic [31:0] m_AADDR;
   logic [2:0]  m_APROT;
   logic [2:0]  o_count;
   logic        o_misaligned;

   logic        a_svalid;
   logic        a_sready;
   logic [31:0] a_saddr;
   logic [2:0]  a_sprot;
   logic        a_mvalid;
   logic        a_mready;
   logic [31:0] a_maddr;
   logic [2:0]  a_mprot;
   logic [2:0]  a_count;
   logic        a_mis;

   int          total;
   int          bad;
   int          mdl_cnt;
   logic        mdl_mis;
   logic [34:0] exp_q[$];

   axil_addr_fifo #(
      .ADDR_WIDTH(32), .DEPTH(4), .DATA_WIDTH(64), .ALIGN_MODE(0)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .s_AVALID(s_AVALID), .s_AREADY(s_AREADY), .s_AADDR(s_AADDR), .s_APROT(s_APROT),
      .m_AVALID(m_AVALID), .m_AREADY(m_AREADY), .m_AADDR(m_AADDR), .m_APROT(m_APROT),
      .o_count(o_count), .o_misaligned(o_misaligned)
   );

   axil_addr_fifo #(
      .ADDR_WIDTH(32), .DEPTH(4), .DATA_WIDTH(64), .ALIGN_MODE(1)
   ) u_align (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .s_AVALID(a_svalid), .s_AREADY(a_sready), .s_AADDR(a_saddr), .s_APROT(a_sprot),
      .m_AVALID(a_mvalid), .m_AREADY(a_mready), .m_AADDR(a_maddr), .m_APROT(a_mprot),
      .o_count(a_count), .o_misaligned(a_mis)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle of stimulus; the bench model decides what the DUT should accept.
   task automatic apply_stimulus(input logic v, input logic [31:0] a, input logic [2:0] p,
                                 input logic rdy);
      logic do_push;
      logic do_pop;
      s_AVALID = v;
      s_AADDR  = a;
      s_APROT  = p;
      m_AREADY = rdy;
      @(negedge ACLK);
      check_output("s_AREADY", 64'(s_AREADY), 64'(mdl_cnt != 4));
      check_output("m_AVALID", 64'(m_AVALID), 64'(mdl_cnt != 0));
      check_output("o_count", 64'(o_count), 64'(mdl_cnt));
      check_output("o_misaligned", 64'(o_misaligned), 64'(mdl_mis));
      do_push = v && (mdl_cnt != 4);
      do_pop  = rdy && (mdl_cnt != 0);
      if (do_push) exp_q.push_back({a, p});
      mdl_mis = do_push && (a[2:0] != 3'b000);
      mdl_cnt = mdl_cnt + int'(do_push) - int'(do_pop);
      @(posedge ACLK);
      #1;
   endtask

   // Head is compared whenever valid, which also covers stability under backpressure.
   always @(negedge ACLK) begin
      if (ARESETn && m_AVALID) begin
         if (exp_q.size() == 0) begin
            check_output("head_unexpected", 64'(m_AADDR), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            check_output("m_AADDR", 64'(m_AADDR), 64'(exp_q[0][34:3]));
            check_output("m_APROT", 64'(m_APROT), 64'(exp_q[0][2:0]));
            if (m_AREADY) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      total    = 0;
      bad      = 0;
      mdl_cnt  = 0;
      mdl_mis  = 1'b0;
      ARESETn  = 1'b0;
      s_AVALID = 1'b0;
      s_AADDR  = '0;
      s_APROT  = '0;
      m_AREADY = 1'b0;
      a_svalid = 1'b0;
      a_saddr  = '0;
      a_sprot  = '0;
      a_mready = 1'b0;

      repeat (2) @(posedge ACLK);
      #1;
      check_output("rst_s_AREADY", 64'(s_AREADY), 64'd0);
      check_output("rst_m_AVALID", 64'(m_AVALID), 64'd0);
      check_output("rst_m_AADDR", 64'(m_AADDR), 64'd0);
      check_output("rst_o_count", 64'(o_count), 64'd0);
      ARESETn = 1'b1;
      @(posedge ACLK);
      #1;
      check_output("ready_after_rst", 64'(s_AREADY), 64'd1);

      $display("[TB] single push/pop");
      apply_stimulus(1'b1, 32'h0000_1000, 3'b010, 1'b0);
      apply_stimulus(1'b0, 32'h0, 3'b000, 1'b1);
      apply_stimulus(1'b0, 32'h0, 3'b000, 1'b0);

      $display("[TB] fill to full and drain");
      for (int k = 0; k < 4; k++) apply_stimulus(1'b1, 32'h10 + 32'(4 * k), 3'(k), 1'b0);
      apply_stimulus(1'b1, 32'h20, 3'b111, 1'b0);
      for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 32'h0, 3'b000, 1'b1);
      apply_stimulus(1'b0, 32'h0, 3'b000, 1'b0);

      $display("[TB] backpressure");
      apply_stimulus(1'b1, 32'h40, 3'b101, 1'b0);
      for (int k = 0; k < 5; k++) apply_stimulus(1'b1, 32'h48 + 32'(8 * k), 3'(k), 1'b0);
      for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 32'h0, 3'b000, 1'b1);
      apply_stimulus(1'b0, 32'h0, 3'b000, 1'b0);

      $display("[TB] streaming at count 2");
      apply_stimulus(1'b1, 32'h100, 3'b000, 1'b0);
      apply_stimulus(1'b1, 32'h104, 3'b001, 1'b0);
      for (int k = 2; k < 22; k++) apply_stimulus(1'b1, 32'h100 + 32'(4 * k), 3'(k), 1'b1);
      apply_stimulus(1'b0, 32'h0, 3'b000, 1'b1);
      apply_stimulus(1'b0, 32'h0, 3'b000, 1'b1);
      apply_stimulus(1'b0, 32'h0, 3'b000, 1'b0);

      $display("[TB] misaligned pass-through");
      apply_stimulus(1'b1, 32'h0000_2007, 3'b001, 1'b0);
      apply_stimulus(1'b0, 32'h0, 3'b000, 1'b1);
      apply_stimulus(1'b0, 32'h0, 3'b000, 1'b0);

      $display("[TB] reset mid-operation");
      apply_stimulus(1'b1, 32'h300, 3'b001, 1'b0);
      apply_stimulus(1'b1, 32'h308, 3'b010, 1'b0);
      apply_stimulus(1'b1, 32'h30C, 3'b011, 1'b0);
      s_AVALID = 1'b0;
      #2;
      ARESETn = 1'b0;
      #1;
      check_output("midrst_o_count", 64'(o_count), 64'd0);
      check_output("midrst_m_AVALID", 64'(m_AVALID), 64'd0);
      check_output("midrst_misaligned", 64'(o_misaligned), 64'd0);
      check_output("midrst_m_AADDR", 64'(m_AADDR), 64'd0);
      check_output("midrst_s_AREADY", 64'(s_AREADY), 64'd0);
      exp_q.delete();
      mdl_cnt = 0;
      mdl_mis = 1'b0;
      @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      @(posedge ACLK);
      #1;
      apply_stimulus(1'b1, 32'h500, 3'b011, 1'b0);
      apply_stimulus(1'b0, 32'h0, 3'b000, 1'b1);
      apply_stimulus(1'b0, 32'h0, 3'b000, 1'b0);

      $display("[TB] aligned instance");
      a_svalid = 1'b1;
      a_saddr  = 32'h0000_2007;
      a_sprot  = 3'b100;
      @(posedge ACLK);
      #1;
      a_svalid = 1'b0;
      check_output("align_m_AVALID", 64'(a_mvalid), 64'd1);
      check_output("align_m_AADDR", 64'(a_maddr), 64'h2000);
      check_output("align_m_APROT", 64'(a_mprot), 64'd4);
      check_output("align_misaligned", 64'(a_mis), 64'd1);
      @(posedge ACLK);
      #1;
      check_output("align_mis_cleared", 64'(a_mis), 64'd0);
      check_output("align_hold_addr", 64'(a_maddr), 64'h2000);

      check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
